// File: rtl/memory_params_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_params_pkg
//  Description : Geometry constants shared by the hit-storage memories and a
//                small address range helper used by the block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package memory_params_pkg;

    // SSID space and the hits-new memory (bitmask rows)
    localparam int SSIDBITS         = 16;
    localparam int COLINDEXBITS_HNM = 5;
    localparam int ROWINDEXBITS_HNM = SSIDBITS - COLINDEXBITS_HNM;
    localparam int NCOLS_HNM        = 2 ** COLINDEXBITS_HNM;
    localparam int NROWS_HNM        = 2 ** ROWINDEXBITS_HNM;

    // Hits-list and hits-count memories
    localparam int ROWINDEXBITS_HLM = 10;
    localparam int MAXHITNBITS      = 2;
    localparam int ROWINDEXBITS_HCM = 10;
    localparam int NCOLS_HCM        = MAXHITNBITS + ROWINDEXBITS_HLM;
    localparam int NROWS_HCM        = 2 ** ROWINDEXBITS_HCM;

    // True when a zero-extended address falls inside a memory of 'depth' words
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input int unsigned depth);
        return addr < depth;
    endfunction

endpackage : memory_params_pkg
`default_nettype wire

// File: rtl/dual_port_block_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dual_port_block_ram
//  Description : Single-clock true-dual-port RAM. Each port is write-first
//                towards itself; across ports a same-address read sees the
//                old word and a double write keeps port A's data.
//                OUT_REG=1 adds an output stage (read latency 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module dual_port_block_ram
    import memory_params_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 2 ** ADDR_WIDTH,
    parameter int OUT_REG    = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    input  logic                  enb,
    input  logic                  web,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb
);

    // Storage starts all-zero; reset never touches it, callers clear by writing
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic [DATA_WIDTH-1:0] douta_q, douta_d;
    logic [DATA_WIDTH-1:0] doutb_q, doutb_d;
    logic                  a_ok, b_ok;
    logic                  wr_a, wr_b;

    // Address qualification, write strobes and next read-register values
    always_comb begin
        a_ok    = addr_in_range(32'(addra), DEPTH);
        b_ok    = addr_in_range(32'(addrb), DEPTH);
        wr_a    = reset_n && ena && wea && a_ok;
        // Port B loses a same-address write collision to port A
        wr_b    = reset_n && enb && web && b_ok && !(wr_a && (addra == addrb));
        douta_d = douta_q;
        doutb_d = doutb_q;
        if (ena) begin
            if (wea)       douta_d = dina;
            else if (a_ok) douta_d = mem_q[addra];
            else           douta_d = '0;
        end
        if (enb) begin
            if (web)       doutb_d = dinb;
            else if (b_ok) doutb_d = mem_q[addrb];
            else           doutb_d = '0;
        end
    end

    // Array update; cross-port reads of the same word see the pre-edge value
    always_ff @(posedge clock) begin
        if (wr_b) mem_q[addrb] <= dinb;
        if (wr_a) mem_q[addra] <= dina;
    end

    // First-stage read registers, cleared by reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            douta_q <= '0;
            doutb_q <= '0;
        end else begin
            douta_q <= douta_d;
            doutb_q <= doutb_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] douta_pipe_q, doutb_pipe_q;
            logic                  ena_q, enb_q;

            // Output stage advances only behind a cycle in which the port was enabled
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    douta_pipe_q <= '0;
                    doutb_pipe_q <= '0;
                    ena_q        <= 1'b0;
                    enb_q        <= 1'b0;
                end else begin
                    if (ena_q) douta_pipe_q <= douta_q;
                    if (enb_q) doutb_pipe_q <= doutb_q;
                    ena_q <= ena;
                    enb_q <= enb;
                end
            end

            assign douta = douta_pipe_q;
            assign doutb = doutb_pipe_q;
        end else begin : g_no_out_reg
            assign douta = douta_q;
            assign doutb = doutb_q;
        end
    endgenerate

endmodule : dual_port_block_ram
`default_nettype wire

// File: tb/tb_dual_port_block_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dual_port_block_ram
//  Description : Self-checking bench for dual_port_block_ram. One instance
//                without and one with the output register share all inputs
//                and are compared against an array-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_port_block_ram;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena, wea, enb, web;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dina, dinb;
    logic [DW-1:0] douta0, doutb0, douta1, doutb1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW-1:0] mem_m [16];
    logic [DW-1:0] a1, b1, a2, b2;
    logic          enap, enbp;

    always #5 clk = ~clk;

    dual_port_block_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .OUT_REG(0)) u_dut0 (
        .clock(clk), .reset_n(rst_n),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0)
    );

    dual_port_block_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .OUT_REG(1)) u_dut1 (
        .clock(clk), .reset_n(rst_n),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rd_m(input logic [AW-1:0] addr);
        return (int'(addr) < DEPTH) ? mem_m[addr] : '0;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs
    function automatic void model_step();
        logic [DW-1:0] na, nb;
        if (!rst_n) begin
            a1 = '0; b1 = '0; a2 = '0; b2 = '0; enap = 1'b0; enbp = 1'b0;
        end else begin
            na = ena ? (wea ? dina : rd_m(addra)) : a1;
            nb = enb ? (web ? dinb : rd_m(addrb)) : b1;
            if (enap) a2 = a1;
            if (enbp) b2 = b1;
            a1 = na; b1 = nb; enap = ena; enbp = enb;
            if (enb && web && int'(addrb) < DEPTH && !(ena && wea && addra == addrb))
                mem_m[addrb] = dinb;
            if (ena && wea && int'(addra) < DEPTH)
                mem_m[addra] = dina;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("douta_or0", douta0, a1);
        chk("doutb_or0", doutb0, b1);
        chk("douta_or1", douta1, a2);
        chk("doutb_or1", doutb1, b2);
    endtask

    task automatic drive(input logic ea, input logic wa, input int aa, input logic [DW-1:0] da,
                         input logic eb, input logic wb, input int ab, input logic [DW-1:0] db);
        ena = ea; wea = wa; addra = AW'(aa); dina = da;
        enb = eb; web = wb; addrb = AW'(ab); dinb = db;
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, 0, 0, 0, '0);
    endtask

    initial begin
        int            seq [6];
        logic [DW-1:0] val [6];

        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        a1 = '0; b1 = '0; a2 = '0; b2 = '0; enap = 1'b0; enbp = 1'b0;
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_douta", douta0, 32'h0);
        chk("rst_doutb1", doutb1, 32'h0);
        rst_n = 1'b1;

        // Basic write on A, read on B
        drive(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, '0); tick();
        drive(0, 0, 0, '0, 1, 0, 5, '0);           tick();
        chk("t1_doutb", doutb0, 32'hDEADBEEF);

        // A writes while B reads the same word: B sees old data
        drive(1, 1, 3, 32'h11, 0, 0, 0, '0);       tick();
        drive(1, 1, 3, 32'h22, 1, 0, 3, '0);       tick();
        chk("t2_old", doutb0, 32'h11);
        drive(0, 0, 0, '0, 1, 0, 3, '0);           tick();
        chk("t2_new", doutb0, 32'h22);

        // Dual-write collision: A wins
        drive(1, 1, 7, 32'hAAAA, 1, 1, 7, 32'h5555); tick();
        drive(0, 0, 0, '0, 1, 0, 7, '0);             tick();
        chk("t3_collide", doutb0, 32'hAAAA);

        // Disabled port holds; same-port write-first
        drive(0, 0, 0, '0, 1, 0, 5, '0);           tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, '0, 0, 0, i + 1, '0);   tick();
        end
        chk("t4_hold", doutb0, 32'hDEADBEEF);
        drive(1, 1, 9, 32'h1234, 0, 0, 0, '0);     tick();
        chk("t4_wfirst", douta0, 32'h1234);

        // Reset clears outputs but not contents
        drive(1, 0, 9, '0, 1, 0, 5, '0);           tick();
        rst_n = 1'b0;                              tick();
        chk("t5_rst_a", douta0, 32'h0);
        chk("t5_rst_b", doutb0, 32'h0);
        chk("t5_rst_a1", douta1, 32'h0);
        rst_n = 1'b1;
        drive(1, 0, 9, '0, 0, 0, 0, '0);           tick();
        chk("t5_keep", douta0, 32'h1234);

        // Output-register latency and streaming
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, '0, 1, 1, i, 32'h100 + DW'(i)); tick();
        end
        seq = '{5, 0, 1, 2, 3, 0};
        val = '{32'hDEADBEEF, 32'h100, 32'h101, 32'h102, 32'h22, 32'h100};
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, seq[k], '0, 0, 0, 0, '0); tick();
            if (k >= 1) chk("t6_stream", douta1, val[k-1]);
        end

        // Randomized traffic, including out-of-range addresses and resets
        for (int n = 0; n < 600; n++) begin
            int aa, ab;
            aa = $urandom_range(0, 15);
            ab = ($urandom_range(0, 3) == 0) ? aa : $urandom_range(0, 15);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, aa, DW'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ab, DW'($urandom));
            rst_n = ($urandom_range(0, 49) != 0);
            tick();
        end
        rst_n = 1'b1;

        // Clear sweep using both ports, then read every word back
        for (int i = 0; i < DEPTH; i += 2) begin
            drive(1, 1, i, '0, 1, 1, i + 1, '0); tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, i, '0, 1, 0, DEPTH - 1 - i, '0); tick();
            chk("clr_a", douta0, 32'h0);
            chk("clr_b", doutb0, 32'h0);
        end
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dual_port_block_ram
`default_nettype wire
